// File: rtl/key_evt_pkg.sv
// Shared encodings for the front-panel key event path: event types, per-key
// FSM states and the counter sizing helper.
package key_evt_pkg;

  localparam int unsigned EVT_TYPE_W = 2;

  typedef enum logic [EVT_TYPE_W-1:0] {
    EVT_SHORT  = 2'd0,
    EVT_LONG   = 2'd1,
    EVT_REPEAT = 2'd2
  } evt_type_t;

  typedef enum logic [1:0] {
    KEY_IDLE  = 2'd0,
    KEY_PRESS = 2'd1,
    KEY_LONG  = 2'd2
  } key_state_t;

  // Counter must hold the larger of the two tick thresholds.
  function automatic int unsigned cnt_width(input int unsigned long_ticks,
                                            input int unsigned repeat_ticks);
    int unsigned max_ticks;
    max_ticks = (long_ticks > repeat_ticks) ? long_ticks : repeat_ticks;
    return $clog2(max_ticks + 1);
  endfunction

endpackage

// File: rtl/key_press_fsm.sv
// Per-key press classifier: SHORT / LONG / REPEAT detection with a one-entry
// pending slot that holds the event until the arbiter takes it.
module key_press_fsm
  import key_evt_pkg::*;
#(
  parameter int unsigned LONG_TICKS   = 100,
  parameter int unsigned REPEAT_TICKS = 20,
  parameter int unsigned CNT_W        = 7
) (
  input  logic                  clk_100Hz,
  input  logic                  rst_n,
  input  logic                  key_in,
  input  logic                  slot_clr,
  output logic                  slot_valid,
  output logic [EVT_TYPE_W-1:0] slot_type,
  output logic                  ovf_evt
);

  key_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             raise;
  evt_type_t        raise_type;
  logic             slot_busy;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    raise      = 1'b0;
    raise_type = EVT_SHORT;
    unique case (state_q)
      KEY_IDLE: begin
        if (key_in) begin
          state_d = KEY_PRESS;
          cnt_d   = CNT_W'(1);
        end
      end
      KEY_PRESS: begin
        if (!key_in) begin
          state_d    = KEY_IDLE;
          cnt_d      = '0;
          raise      = 1'b1;
          raise_type = EVT_SHORT;
        end else if (cnt_inc == CNT_W'(LONG_TICKS)) begin
          state_d    = KEY_LONG;
          cnt_d      = '0;
          raise      = 1'b1;
          raise_type = EVT_LONG;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      KEY_LONG: begin
        if (!key_in) begin
          state_d = KEY_IDLE;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_W'(REPEAT_TICKS)) begin
          cnt_d      = '0;
          raise      = 1'b1;
          raise_type = EVT_REPEAT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = KEY_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= KEY_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A slot being granted this edge is free for a newly raised event.
  assign slot_busy = slot_valid && !slot_clr;
  assign ovf_evt   = raise && slot_busy;

  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= 1'b0;
      slot_type  <= '0;
    end else if (raise && !slot_busy) begin
      slot_valid <= 1'b1;
      slot_type  <= raise_type;
    end else if (slot_clr) begin
      slot_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/key_event_scheduler.sv
// Multi-key event front end: per-key classifiers, round-robin arbitration of
// pending events and a show-ahead FIFO towards the mode/menu FSM.
module key_event_scheduler
  import key_evt_pkg::*;
#(
  parameter int unsigned NUM_KEYS     = 5,
  parameter int unsigned LONG_TICKS   = 100,
  parameter int unsigned REPEAT_TICKS = 20,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                        clk_100Hz,
  input  logic                        rst_n,
  input  logic [NUM_KEYS-1:0]         key_in,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [$clog2(NUM_KEYS)-1:0] evt_key,
  output logic [EVT_TYPE_W-1:0]       evt_type,
  output logic                        overflow,
  input  logic                        clr_overflow
);

  localparam int unsigned KEY_W = $clog2(NUM_KEYS);
  localparam int unsigned CNT_W = cnt_width(LONG_TICKS, REPEAT_TICKS);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);

  logic [NUM_KEYS-1:0]   pend, slot_clr, ovf_vec;
  logic [EVT_TYPE_W-1:0] pend_type [NUM_KEYS];

  logic                  grant_valid;
  logic [KEY_W-1:0]      grant_idx, cand, rr_ptr;
  logic [EVT_TYPE_W-1:0] grant_type;
  logic                  push, pop, full;

  logic [KEY_W-1:0]      mem_key  [FIFO_DEPTH];
  logic [EVT_TYPE_W-1:0] mem_type [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic [KEY_W-1:0]      last_key;
  logic [EVT_TYPE_W-1:0] last_type;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_press_fsm #(
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS),
      .CNT_W       (CNT_W)
    ) u_key (
      .clk_100Hz (clk_100Hz),
      .rst_n     (rst_n),
      .key_in    (key_in[k]),
      .slot_clr  (slot_clr[k]),
      .slot_valid(pend[k]),
      .slot_type (pend_type[k]),
      .ovf_evt   (ovf_vec[k])
    );
    assign slot_clr[k] = push && (grant_idx == KEY_W'(k));
  end

  function automatic logic [KEY_W-1:0] rr_pick(input logic [KEY_W-1:0] base,
                                               input int unsigned offset);
    int unsigned sum;
    sum = {{(32-KEY_W){1'b0}}, base} + offset;
    if (sum >= NUM_KEYS) sum = sum - NUM_KEYS;
    return KEY_W'(sum);
  endfunction

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_type  = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      cand = rr_pick(rr_ptr, i);
      if (!grant_valid && pend[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
        grant_type  = pend_type[cand];
      end
    end
  end

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign evt_valid = (count != '0);
  assign pop       = evt_valid && evt_ready;
  assign push      = grant_valid && (!full || pop);

  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (grant_idx == KEY_W'(NUM_KEYS-1)) ? '0 : grant_idx + KEY_W'(1);
    end
  end

  always_ff @(posedge clk_100Hz) begin
    if (push) begin
      mem_key[wr_ptr]  <= grant_idx;
      mem_type[wr_ptr] <= grant_type;
    end
  end

  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_key  <= '0;
      last_type <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        last_key  <= mem_key[rd_ptr];
        last_type <= mem_type[rd_ptr];
      end
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Empty FIFO keeps presenting the most recently consumed event.
  assign evt_key  = evt_valid ? mem_key[rd_ptr]  : last_key;
  assign evt_type = evt_valid ? mem_type[rd_ptr] : last_type;

  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (|ovf_vec) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed bench for key_event_scheduler: press classification, arbitration
// order, FIFO back-pressure with overflow, and reset behaviour.
module tb_key_event_scheduler;

  logic       clk_100Hz;
  logic       rst_n;
  logic [4:0] key_in;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_key;
  logic [1:0] evt_type;
  logic       overflow;
  logic       clr_overflow;

  typedef struct {
    int key;
    int typ;
    int stamp;
  } ev_t;

  ev_t evq[$];
  int  cyc    = 0;
  int  passed = 0;
  int  total  = 0;

  key_event_scheduler #(
    .NUM_KEYS    (5),
    .LONG_TICKS  (100),
    .REPEAT_TICKS(20),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk_100Hz   (clk_100Hz),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_key     (evt_key),
    .evt_type    (evt_type),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
  );

  initial clk_100Hz = 1'b0;
  always #5 clk_100Hz = ~clk_100Hz;

  // Consumed events, stamped with the number of edges preceding the pop edge.
  always @(posedge clk_100Hz) begin
    if (evt_valid === 1'b1 && evt_ready === 1'b1)
      evq.push_back('{int'(evt_key), int'(evt_type), cyc});
    cyc <= cyc + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_100Hz);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    tick(2);
    total++; if (evt_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", evt_valid); else passed++;
    total++; if (evt_key !== 3'd0) $display("FAIL reset_key: got %0d expected 0", evt_key); else passed++;
    total++; if (evt_type !== 2'd0) $display("FAIL reset_type: got %0d expected 0", evt_type); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %0b expected 0", overflow); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_short();
    int s;
    evq.delete();
    evt_ready = 1'b1;
    key_in = 5'b00001;
    s = cyc;
    tick(3);
    key_in = 5'b00000;
    tick(1);
    total++; if (evt_valid !== 1'b0) $display("FAIL short_not_yet: valid got %0b expected 0", evt_valid); else passed++;
    tick(1);
    total++; if (evt_valid !== 1'b1) $display("FAIL short_valid: got %0b expected 1", evt_valid); else passed++;
    total++; if (evt_key !== 3'd0 || evt_type !== 2'd0)
      $display("FAIL short_head: got key %0d type %0d expected key 0 type 0", evt_key, evt_type); else passed++;
    tick(1);
    total++; if (evt_valid !== 1'b0) $display("FAIL short_one_cycle: valid got %0b expected 0", evt_valid); else passed++;
    tick(2);
    total++;
    if (evq.size() != 1) $display("FAIL short_count: got %0d events expected 1", evq.size());
    else if (evq[0].key != 0 || evq[0].typ != 0 || evq[0].stamp != s + 5)
      $display("FAIL short_evt: got key %0d type %0d at %0d expected key 0 type 0 at %0d",
               evq[0].key, evq[0].typ, evq[0].stamp, s + 5);
    else passed++;
  endtask

  task automatic test_long_boundary();
    int s;
    evq.delete();
    key_in = 5'b00100;
    s = cyc;
    tick(99);
    key_in = 5'b00000;
    tick(4);
    total++;
    if (evq.size() != 1) $display("FAIL b99_count: got %0d events expected 1", evq.size());
    else if (evq[0].key != 2 || evq[0].typ != 0 || evq[0].stamp != s + 101)
      $display("FAIL b99_evt: got key %0d type %0d at %0d expected key 2 type 0 at %0d",
               evq[0].key, evq[0].typ, evq[0].stamp, s + 101);
    else passed++;

    evq.delete();
    key_in = 5'b00100;
    s = cyc;
    tick(100);
    total++; if (evt_valid !== 1'b0) $display("FAIL b100_early: valid got %0b expected 0", evt_valid); else passed++;
    tick(1);
    total++; if (evt_valid !== 1'b1 || evt_key !== 3'd2 || evt_type !== 2'd1)
      $display("FAIL b100_head: got valid %0b key %0d type %0d expected valid 1 key 2 type 1",
               evt_valid, evt_key, evt_type); else passed++;
    tick(1);
    key_in = 5'b00000;
    tick(4);
    total++;
    if (evq.size() != 1) $display("FAIL b100_count: got %0d events expected 1", evq.size());
    else if (evq[0].key != 2 || evq[0].typ != 1 || evq[0].stamp != s + 101)
      $display("FAIL b100_evt: got key %0d type %0d at %0d expected key 2 type 1 at %0d",
               evq[0].key, evq[0].typ, evq[0].stamp, s + 101);
    else passed++;
    total++; if (evt_valid !== 1'b0 || evt_key !== 3'd2 || evt_type !== 2'd1)
      $display("FAIL hold_last: got valid %0b key %0d type %0d expected valid 0 key 2 type 1",
               evt_valid, evt_key, evt_type); else passed++;
  endtask

  task automatic test_repeat();
    int s;
    int ek[3] = '{1, 1, 1};
    int et[3] = '{1, 2, 2};
    int es[3] = '{101, 121, 141};
    evq.delete();
    key_in = 5'b00010;
    s = cyc;
    tick(140);
    key_in = 5'b00000;
    tick(4);
    total++; if (evq.size() != 3) $display("FAIL rep_count: got %0d events expected 3", evq.size()); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (evq.size() <= i)
        $display("FAIL rep_evt%0d: got no event expected key %0d type %0d at %0d", i, ek[i], et[i], s + es[i]);
      else if (evq[i].key != ek[i] || evq[i].typ != et[i] || evq[i].stamp != s + es[i])
        $display("FAIL rep_evt%0d: got key %0d type %0d at %0d expected key %0d type %0d at %0d",
                 i, evq[i].key, evq[i].typ, evq[i].stamp, ek[i], et[i], s + es[i]);
      else passed++;
    end
  endtask

  task automatic test_round_robin();
    int s;
    int ek0[3] = '{0, 3, 4};
    int ek4[3] = '{4, 0, 3};
    apply_reset();
    evt_ready = 1'b1;
    evq.delete();
    key_in = 5'b11001;
    s = cyc;
    tick(3);
    key_in = 5'b00000;
    tick(6);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (evq.size() <= i)
        $display("FAIL rr0_evt%0d: got no event expected key %0d at %0d", i, ek0[i], s + 5 + i);
      else if (evq[i].key != ek0[i] || evq[i].typ != 0 || evq[i].stamp != s + 5 + i)
        $display("FAIL rr0_evt%0d: got key %0d type %0d at %0d expected key %0d type 0 at %0d",
                 i, evq[i].key, evq[i].typ, evq[i].stamp, ek0[i], s + 5 + i);
      else passed++;
    end

    // A lone key 3 grant leaves the pointer at 4.
    key_in = 5'b01000;
    tick(3);
    key_in = 5'b00000;
    tick(4);
    evq.delete();
    key_in = 5'b11001;
    s = cyc;
    tick(3);
    key_in = 5'b00000;
    tick(6);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (evq.size() <= i)
        $display("FAIL rr4_evt%0d: got no event expected key %0d at %0d", i, ek4[i], s + 5 + i);
      else if (evq[i].key != ek4[i] || evq[i].typ != 0 || evq[i].stamp != s + 5 + i)
        $display("FAIL rr4_evt%0d: got key %0d type %0d at %0d expected key %0d type 0 at %0d",
                 i, evq[i].key, evq[i].typ, evq[i].stamp, ek4[i], s + 5 + i);
      else passed++;
    end
  endtask

  task automatic test_overflow();
    int s;
    apply_reset();
    evt_ready = 1'b0;
    evq.delete();
    key_in = 5'b11111;
    tick(3);
    key_in = 5'b00000;
    tick(6);
    total++; if (evt_valid !== 1'b1 || evt_key !== 3'd0 || overflow !== 1'b0)
      $display("FAIL full_state: got valid %0b key %0d ovf %0b expected valid 1 key 0 ovf 0",
               evt_valid, evt_key, overflow); else passed++;
    key_in = 5'b10000;
    tick(2);
    key_in = 5'b00000;
    tick(1);
    total++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %0b expected 1", overflow); else passed++;
    evt_ready = 1'b1;
    s = cyc;
    tick(7);
    total++; if (evq.size() != 5) $display("FAIL drain_count: got %0d events expected 5", evq.size()); else passed++;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (evq.size() <= i)
        $display("FAIL drain_evt%0d: got no event expected key %0d at %0d", i, i, s + i);
      else if (evq[i].key != i || evq[i].typ != 0 || evq[i].stamp != s + i)
        $display("FAIL drain_evt%0d: got key %0d type %0d at %0d expected key %0d type 0 at %0d",
                 i, evq[i].key, evq[i].typ, evq[i].stamp, i, s + i);
      else passed++;
    end
    total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %0b expected 1", overflow); else passed++;
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    total++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %0b expected 0", overflow); else passed++;
  endtask

  task automatic test_reset_mid();
    int s;
    apply_reset();
    evt_ready = 1'b0;
    evq.delete();
    key_in = 5'b00011;
    tick(3);
    key_in = 5'b00010;
    tick(100);
    total++; if (evt_valid !== 1'b1) $display("FAIL mid_pre_valid: got %0b expected 1", evt_valid); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (evt_valid !== 1'b0 || overflow !== 1'b0)
      $display("FAIL mid_async: got valid %0b ovf %0b expected valid 0 ovf 0", evt_valid, overflow); else passed++;
    tick(2);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    s = cyc;
    tick(100);
    total++; if (evq.size() != 0 || evt_valid !== 1'b0)
      $display("FAIL mid_flushed: got %0d events valid %0b expected 0 events valid 0", evq.size(), evt_valid);
    else passed++;
    tick(3);
    total++;
    if (evq.size() != 1) $display("FAIL mid_relong_count: got %0d events expected 1", evq.size());
    else if (evq[0].key != 1 || evq[0].typ != 1 || evq[0].stamp != s + 101)
      $display("FAIL mid_relong: got key %0d type %0d at %0d expected key 1 type 1 at %0d",
               evq[0].key, evq[0].typ, evq[0].stamp, s + 101);
    else passed++;
    key_in = 5'b00000;
    tick(2);
  endtask

  initial begin
    rst_n        = 1'b0;
    key_in       = '0;
    evt_ready    = 1'b0;
    clr_overflow = 1'b0;
    test_reset();
    test_short();
    test_long_boundary();
    test_repeat();
    test_round_robin();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
